// File: rtl/muldiv_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle RV32M multiply/divide unit with valid/ready request
//            and response ports. Optional macro MULDIV_EARLY_OUT_EN enables
//            small-dividend early-out and leading-zero skip in the divider.
// Revision : 1.0 - initial release
//==============================================================================
module muldiv_sequencer #(
  parameter int MUL_LATENCY = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam int                  C_CNT_W    = $clog2(XLEN);
  localparam int                  C_LZ_W     = C_CNT_W + 1;
  localparam logic [C_CNT_W-1:0]  C_MUL_LAST = C_CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
  localparam logic [XLEN-1:0]     C_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [1:0]           r_op;
  logic [4:0]           r_rd;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [XLEN-1:0]      r_dvs;
  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_quo;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [XLEN-1:0]      r_data;

  logic                 w_accept;
  logic                 w_sgn;
  logic                 w_div0;
  logic                 w_ovf;
  logic                 w_special;
  logic                 w_early;
  logic [XLEN-1:0]      w_mag_a;
  logic [XLEN-1:0]      w_mag_b;
  logic [XLEN-1:0]      w_special_res;
  logic [1:0]           w_mop;
  logic [XLEN-1:0]      w_ma;
  logic [XLEN-1:0]      w_mb;
  logic                 w_sa;
  logic                 w_sb;
  logic [2*XLEN-1:0]    w_prod;
  logic [XLEN-1:0]      w_mul_res;
  logic [XLEN:0]        w_shift;
  logic [XLEN:0]        w_trial;
  logic [XLEN-1:0]      w_q_fix;
  logic [XLEN-1:0]      w_r_fix;

  assign req_ready  = (r_state == S_IDLE) && !flush && !rst;
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_data  = r_data;
  assign resp_rd    = r_rd;
  assign w_accept   = req_valid && req_ready;

  // Divide-side decode on the raw request; op[0]=0 marks the signed DIV/REM.
  assign w_sgn         = !req_op[0];
  assign w_mag_a       = (w_sgn && req_rs1[XLEN-1]) ? -req_rs1 : req_rs1;
  assign w_mag_b       = (w_sgn && req_rs2[XLEN-1]) ? -req_rs2 : req_rs2;
  assign w_div0        = (req_rs2 == '0);
  assign w_ovf         = w_sgn && (req_rs1 == C_MIN) && (req_rs2 == '1);
  assign w_special     = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (req_op[1] ? req_rs1 : '1) : (req_op[1] ? '0 : C_MIN);

`ifdef MULDIV_EARLY_OUT_EN
  logic [C_LZ_W-1:0] w_lz;

  always_comb begin
    w_lz = C_LZ_W'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (w_mag_a[i]) w_lz = C_LZ_W'(XLEN - 1 - i);
    end
  end

  assign w_early = (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  // The request-side operands feed the multiplier only for single-cycle latency.
  assign w_mop     = (r_state == S_IDLE) ? req_op[1:0] : r_op;
  assign w_ma      = (r_state == S_IDLE) ? req_rs1 : r_a;
  assign w_mb      = (r_state == S_IDLE) ? req_rs2 : r_b;
  assign w_sa      = (w_mop == 2'd1) || (w_mop == 2'd2);
  assign w_sb      = (w_mop == 2'd1);
  assign w_prod    = {{XLEN{w_sa & w_ma[XLEN-1]}}, w_ma} * {{XLEN{w_sb & w_mb[XLEN-1]}}, w_mb};
  assign w_mul_res = (w_mop == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!req_op[2])     w_next = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
          else if (w_special) w_next = S_DONE;
          else if (w_early)   w_next = S_FIX;
          else                w_next = S_DIV;
        end
      end
      S_MUL:   if (r_cnt == C_MUL_LAST) w_next = S_DONE;
      S_DIV:   if (r_cnt == '1)         w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (resp_ready)          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op[1:0];
            r_rd    <= req_rd;
            r_a     <= req_rs1;
            r_b     <= req_rs2;
            r_dvs   <= w_mag_b;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_cnt   <= '0;
            r_neg_q <= w_sgn && (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]);
            r_neg_r <= w_sgn && req_rs1[XLEN-1];
`ifdef MULDIV_EARLY_OUT_EN
            if (req_op[2]) begin
              // Pre-shift the dividend so the first iteration sees its MSB.
              r_cnt <= w_lz[C_CNT_W-1:0];
              r_quo <= w_mag_a << w_lz;
              if (w_early) begin
                r_quo <= '0;
                r_rem <= w_mag_a;
              end
            end
`endif
            if (req_op[2]) begin
              if (w_special) r_data <= w_special_res;
            end else if (MUL_LATENCY == 1) begin
              r_data <= w_mul_res;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_MUL_LAST) r_data <= w_mul_res;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
        end
        S_FIX:   r_data <= r_op[1] ? w_r_fix : w_q_fix;
        default: ;
      endcase
    end
  end

  a_valid_only_in_done: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> (r_state == S_DONE));

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle RV32M multiply/divide unit with its sequencing controller. It replaces single-cycle combinational M-extension arithmetic in the execute stage. EX issues an M-op through a valid/ready request port and holds the pipeline while the unit is busy. The registered result returns on a valid/ready response port toward EX/MEM writeback.

Parameters:
MUL_LATENCY, 2, cycles from request accept to resp_valid for multiply ops; legal range 1..4.
XLEN, 32, operand width; only 32 is supported.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  1  EX presents an M-op
req_ready  output  1  unit can accept; high only in IDLE, not in flush, not in reset
req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_rs1  input  32  operand A, already forwarded
req_rs2  input  32  operand B, already forwarded
req_rd  input  5  destination register tag
flush  input  1  kill the in-flight op (branch mispredict)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  32  result
resp_rd  output  5  destination tag captured at accept
busy  output  1  state != IDLE; drives the EX stall

Behaviour:
- Reset (async, rst=1): state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, counter=0, req_ready=0, busy=0. Outputs take these values immediately, without a clock edge.
- Accept: a request is accepted on the edge where req_valid&&req_ready; call that cycle T. Operands, op and rd are latched into registers.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE transitions:
  - MUL ops go to MUL.
  - DIV/REM with divisor==0 or overflow (rs1=0x80000000, rs2=0xFFFFFFFF, signed ops) go directly to DONE.
  - All other DIV/REM ops go to DIV.
- MUL:
  - Computes the 64-bit product: signed×signed for MULH, signed×unsigned for MULHSU, unsigned×unsigned for MULHU and MUL.
  - Counter runs MUL_LATENCY-1 cycles, then the state goes to DONE.
  - resp_valid first high in cycle T+MUL_LATENCY.
  - MUL returns product[31:0]; the others return product[63:32].
- DIV:
  - Restoring divide on operand magnitudes, one quotient bit per cycle, 32 cycles.
  - Then FIX for 1 cycle: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Then DONE. resp_valid first high in cycle T+34.
- Special results (resp_valid at T+1):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Overflow: DIV returns 0x80000000; REM returns 0.
- DONE: resp_valid=1. resp_data and resp_rd stay stable until resp_valid&&resp_ready, then the state goes to IDLE. req_ready rises the cycle after the handshake; there is no same-cycle turnaround.
- resp_valid deasserts in the cycle after the handshake.
- flush in any state: next state is IDLE, resp_valid=0 next cycle, and the response is dropped. flush in IDLE blocks acceptance.
- flush together with a resp handshake in DONE: the handshake completes and the state goes to IDLE.
- req_valid ignored while busy; the requester holds its values.
- Assertion: resp_valid never high in IDLE/MUL/DIV/FIX.

Optional Feature:
MULDIV_EARLY_OUT_EN defined:
- In IDLE, a non-special DIV/REM whose |rs1| < |rs2| (unsigned compare of magnitudes) goes directly to FIX with quotient=0 and remainder=dividend.
- resp_valid at T+2.
- Also skips leading zero bits: the counter starts at the dividend magnitude's leading-zero count, so latency is 34-lz.

Undefined: fixed latency, 34 cycles for every non-special divide.

Test Plan:
- MUL_LATENCY=2, MUL rs1=0x00000007 rs2=0xFFFFFFFD: resp_valid at T+2, data 0xFFFFFFEB. MULH gives 0xFFFFFFFF; MULHU gives 0x00000006; MULHSU rs1=0xFFFFFFFF rs2=2 gives 0xFFFFFFFF.
- DIV 0xFFFFFFEC/0x00000003 gives 0xFFFFFFFA; REM gives 0xFFFFFFFE; DIVU 100/7 gives 14; REMU gives 2. All at T+34, macro off.
- DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0. All at T+1.
- Hold resp_ready=0 for 5 cycles in DONE: resp_valid, resp_data and resp_rd stay stable, req_ready=0, busy=1. After the handshake, req_ready=1 the next cycle.
- flush at T+10 of a DIV: IDLE next cycle and no resp_valid. A following MUL 3×4 returns 12 with the correct rd.
- Assert rst mid-MUL between clock edges: resp_valid=0, busy=0, resp_data=0 immediately. After release, the unit accepts a new request.
